// File: rtl/sync_gray_ptr_multi.sv
// sync_gray_ptr_multi: multi-channel Gray pointer synchroniser into wclk.
// Per channel: SYNC_STAGES-deep flop chain, registered Gray->binary value,
// advance pulse/delta and an optional sticky Gray-integrity error.
// Optional feature macro: SYNC_GRAY_CHECK_EN (Hamming checker + gray_err).

module sync_gray_ptr_ch #(
   parameter int P      = 9,
   parameter int STAGES = 2
) (
   input  logic         wclk,
   input  logic         wrst,
   input  logic         out_valid,
   input  logic [P-1:0] gray_in,
   input  logic         err_clr,
   output logic [P-1:0] gray_o,
   output logic [P-1:0] bin_o,
   output logic [P-1:0] delta_o,
   output logic         adv_o,
   output logic         err_o
);

   logic [STAGES-1:0][P-1:0] sync_q, sync_d;
   logic [P-1:0]             bin_q, bin_d;
   logic [P-1:0]             delta_q, delta_d;
   logic                     adv_q, adv_d;

   function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
      logic [P-1:0] b;
      b[P-1] = g[P-1];
      for (int i = P - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Sync chain shift, binary conversion and advance detection.
   // bin_q doubles as the previous-value register: bin_d is the new value.
   always_comb begin
      sync_d[0] = gray_in;
      for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
      bin_d   = gray2bin(sync_q[STAGES-1]);
      adv_d   = out_valid && (bin_d != bin_q);
      delta_d = adv_d ? (bin_d - bin_q) : delta_q;
   end

   // State registers; synchronous reset discards everything in flight.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         sync_q  <= '0;
         bin_q   <= '0;
         delta_q <= '0;
         adv_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         bin_q   <= bin_d;
         delta_q <= delta_d;
         adv_q   <= adv_d;
      end
   end

   assign gray_o  = sync_q[STAGES-1];
   assign bin_o   = bin_q;
   assign delta_o = delta_q;
   assign adv_o   = adv_q;

`ifdef SYNC_GRAY_CHECK_EN
   logic         err_q, err_d;
   logic [P-1:0] prev_gray, diff;

   // Previous Gray value is re-derived from bin_q; >1 differing bit is an error.
   // Set has priority over clear.
   always_comb begin
      prev_gray = bin_q ^ (bin_q >> 1);
      diff      = sync_q[STAGES-1] ^ prev_gray;
      err_d     = (out_valid && ((diff & (diff - 1'b1)) != '0)) || (err_q && !err_clr);
   end

   // Sticky error flag.
   always_ff @(posedge wclk) begin
      if (wrst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err_o = err_q;
`else
   logic err_clr_unused;
   assign err_clr_unused = err_clr;
   assign err_o          = 1'b0;
`endif

endmodule

module sync_gray_ptr_multi #(
   parameter int ADDRSIZE    = 8,
   parameter int NUM_CH      = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           wclk,
   input  logic                           wrst,
   input  logic [NUM_CH*(ADDRSIZE+1)-1:0] rptr_gray,
   input  logic [NUM_CH-1:0]              err_clr,
   output logic [NUM_CH*(ADDRSIZE+1)-1:0] wq_rptr_gray,
   output logic [NUM_CH*(ADDRSIZE+1)-1:0] wq_rptr_bin,
   output logic [NUM_CH-1:0]              ptr_adv,
   output logic [NUM_CH*(ADDRSIZE+1)-1:0] adv_delta,
   output logic                           out_valid,
   output logic [NUM_CH-1:0]              gray_err
);

   localparam int P  = ADDRSIZE + 1;
   localparam int CW = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0] FILL_MAX = CW'(SYNC_STAGES + 1);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("sync_gray_ptr_multi: SYNC_STAGES must be 2..4");
   end
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
      $error("sync_gray_ptr_multi: NUM_CH must be 1..8");
   end

   logic [CW-1:0] fill_q, fill_d;

   // Saturating count of edges since reset release.
   always_comb begin
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + CW'(1);
   end

   // Fill counter register.
   always_ff @(posedge wclk) begin
      if (wrst) fill_q <= '0;
      else      fill_q <= fill_d;
   end

   // Valid once the chain and binary stage hold post-reset samples.
   assign out_valid = (fill_q == FILL_MAX);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sync_gray_ptr_ch #(.P(P), .STAGES(SYNC_STAGES)) u_ch (
         .wclk      (wclk),
         .wrst      (wrst),
         .out_valid (out_valid),
         .gray_in   (rptr_gray[c*P +: P]),
         .err_clr   (err_clr[c]),
         .gray_o    (wq_rptr_gray[c*P +: P]),
         .bin_o     (wq_rptr_bin[c*P +: P]),
         .delta_o   (adv_delta[c*P +: P]),
         .adv_o     (ptr_adv[c]),
         .err_o     (gray_err[c])
      );
   end

endmodule
